// File: rtl/fft_sample_loader_pkg.sv
// Shared types and helpers for the FFT sample loader.
// Holds frame geometry defaults, loader states and address bit reversal.
package fft_pkg;

  localparam int FFT_ADDR_W = 10;
  localparam int FFT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } loader_state_t;

  function automatic logic [15:0] bitrev(
    input logic [15:0] v,
    input int unsigned w
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[i] = v[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream and RAM write port bundle for the FFT loader.
// master drives samples and observes writes; slave is the loader.
interface fft_sample_loader_if
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ram_we;
  logic [15:0]       ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, ram_we, ram_addr, ram_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_we, ram_addr, ram_data
  );

endinterface

// File: rtl/fft_bitrev_addr.sv
// Maps a sample index to its RAM address.
// Bit-reversed when BIT_REV is set so the FFT reads natural order.
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int ADDR_W  = FFT_ADDR_W,
  parameter bit BIT_REV = 1'b1
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr
);

  logic [15:0] rev;
  logic        rev_unused;

  assign rev = bitrev(16'(idx), ADDR_W);
  assign rev_unused = &{1'b0, rev};
  assign addr = BIT_REV ? rev[ADDR_W-1:0] : idx;

endmodule

// File: rtl/fft_sample_loader.sv
// Captures one N-point frame from a sample stream into the FFT RAM.
// Holds the frame until the consumer acknowledges it.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W  = FFT_ADDR_W,
  parameter int DATA_W  = FFT_DATA_W,
  parameter bit BIT_REV = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                frame_ack,
  fft_sample_loader_if.slave  bus,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         drop_cnt
);

  loader_state_t     state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] wr_addr;
  logic              rdy;
  logic              accept;
  logic              last;

  fft_bitrev_addr #(
    .ADDR_W  (ADDR_W),
    .BIT_REV (BIT_REV)
  ) u_addr (
    .idx  (idx),
    .addr (wr_addr)
  );

  assign rdy         = (state == FILL);
  assign bus.s_ready = rdy;
  assign busy        = (state != IDLE);
  assign accept      = bus.s_valid & rdy;
  assign last        = (idx == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      frame_done   <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      bus.ram_we <= accept;
      frame_done <= accept & last;
      if (accept) begin
        bus.ram_addr <= 16'(wr_addr);
        bus.ram_data <= bus.s_data;
      end
      // Offers refused while not ready are counted, never wrapping.
      if (bus.s_valid && !rdy && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            state <= FILL;
            idx   <= '0;
          end
        end
        (state == FILL): begin
          if (accept) begin
            if (last) begin
              state <= FULL;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        (state == FULL): begin
          if (frame_ack) begin
            state <= start ? FILL : IDLE;
            idx   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench: two loaders (bit-reversed and natural order,
// 8-point frames) share one stimulus stream against a frame model.
module tb_fft_sample_loader;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_FULL = 2;

  typedef struct {
    logic [15:0] ar;
    logic [15:0] an;
    logic [15:0] data;
    bit          last;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        frame_ack = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;

  logic        busy_r, busy_n, done_r, done_n;
  logic [15:0] drop_r, drop_n;

  fft_sample_loader_if #(.DATA_W(16)) bus_r ();
  fft_sample_loader_if #(.DATA_W(16)) bus_n ();

  assign bus_r.s_valid = s_valid;
  assign bus_r.s_data  = s_data;
  assign bus_n.s_valid = s_valid;
  assign bus_n.s_data  = s_data;

  fft_sample_loader #(
    .ADDR_W(3), .DATA_W(16), .BIT_REV(1'b1)
  ) dut_r (
    .clk(clk), .rst(rst), .start(start), .frame_ack(frame_ack),
    .bus(bus_r), .busy(busy_r), .frame_done(done_r), .drop_cnt(drop_r)
  );

  fft_sample_loader #(
    .ADDR_W(3), .DATA_W(16), .BIT_REV(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .start(start), .frame_ack(frame_ack),
    .bus(bus_n), .busy(busy_n), .frame_done(done_n), .drop_cnt(drop_n)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  int   m_state = M_IDLE;
  int   m_count = 0;
  int   m_drops = 0;
  int   m_cyc = 0;
  exp_t expq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t",
                  nm, act, req, $time);
  endtask

  function automatic int rev3(input int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  task automatic model(input bit v, input logic [15:0] d,
                       input bit st, input bit ack, input bit r);
    exp_t e;
    m_cyc++;
    if (r) begin
      m_state = M_IDLE;
      m_count = 0;
      m_drops = 0;
      expq.delete();
      return;
    end
    if (v && m_state != M_FILL && m_drops < 65535) m_drops++;
    if (m_state == M_IDLE) begin
      if (st) begin
        m_state = M_FILL;
        m_count = 0;
      end
    end else if (m_state == M_FILL) begin
      if (v) begin
        e.ar   = 16'(rev3(m_count));
        e.an   = 16'(m_count);
        e.data = d;
        e.last = (m_count == 7);
        e.cyc  = m_cyc;
        expq.push_back(e);
        m_count++;
        if (m_count == 8) begin
          m_state = M_FULL;
          m_count = 0;
        end
      end
    end else if (ack) begin
      m_state = st ? M_FILL : M_IDLE;
      m_count = 0;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d,
                      input bit st, input bit ack, input bit r);
    s_valid   = v;
    s_data    = d;
    start     = st;
    frame_ack = ack;
    rst       = r;
    @(posedge clk);
    model(v, d, st, ack, r);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("s_ready_r", 32'(bus_r.s_ready), 32'(m_state == M_FILL));
      chk("s_ready_n", 32'(bus_n.s_ready), 32'(m_state == M_FILL));
      chk("busy_r", 32'(busy_r), 32'(m_state != M_IDLE));
      chk("busy_n", 32'(busy_n), 32'(m_state != M_IDLE));
      chk("drop_r", 32'(drop_r), 32'(m_drops));
      chk("drop_n", 32'(drop_n), 32'(m_drops));
      if (bus_r.ram_we || bus_n.ram_we) begin
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got we=%0b/%0b, expected none",
                   bus_r.ram_we, bus_n.ram_we);
        end else begin
          e = expq.pop_front();
          chk("we_r", 32'(bus_r.ram_we), 32'd1);
          chk("we_n", 32'(bus_n.ram_we), 32'd1);
          chk("addr_r", 32'(bus_r.ram_addr), 32'(e.ar));
          chk("addr_n", 32'(bus_n.ram_addr), 32'(e.an));
          chk("data_r", 32'(bus_r.ram_data), 32'(e.data));
          chk("data_n", 32'(bus_n.ram_data), 32'(e.data));
          chk("done_r", 32'(done_r), 32'(e.last));
          chk("done_n", 32'(done_n), 32'(e.last));
          chk("write_cycle", 32'(m_cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_done_r", 32'(done_r), 32'd0);
        chk("idle_done_n", 32'(done_n), 32'd0);
      end
    end
  end

  initial begin
    step(0, 16'h0, 0, 0, 1);
    mon_en = 1'b1;
    step(0, 16'h0, 0, 0, 1);
    chk("rst_addr_r", 32'(bus_r.ram_addr), 32'd0);
    chk("rst_data_r", 32'(bus_r.ram_data), 32'd0);
    chk("rst_we_r", 32'(bus_r.ram_we), 32'd0);

    // Frame 1: continuous input.
    step(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 16'(16'h0010 + k), 0, 0, 0);
    // Backpressure while FULL.
    for (int k = 0; k < 5; k++) step(1, 16'($urandom), 0, 0, 0);
    chk("full_drop_r", 32'(drop_r), 32'd5);
    chk("full_drop_n", 32'(drop_n), 32'd5);
    step(0, 16'h0, 1, 1, 0);

    // Frame 2: gappy input.
    for (int k = 0; k < 16; k++)
      step(k % 2 == 0, 16'($urandom), 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);

    // Reset mid-frame, then a clean refill.
    step(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 16'($urandom), 0, 0, 0);
    step(0, 16'h0, 0, 0, 1);
    chk("mid_rst_addr_r", 32'(bus_r.ram_addr), 32'd0);
    chk("mid_rst_data_n", 32'(bus_n.ram_data), 32'd0);
    chk("mid_rst_busy_r", 32'(busy_r), 32'd0);
    step(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 16'($urandom), 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step($urandom_range(3, 0) != 0, 16'($urandom),
           $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(199, 0) == 0);

    // Drop counter saturation while idle.
    step(0, 16'h0, 0, 0, 1);
    for (int k = 0; k < 70000; k++) step(1, 16'($urandom), 0, 0, 0);
    chk("sat_drop_r", 32'(drop_r), 32'h0000FFFF);
    chk("sat_drop_n", 32'(drop_n), 32'h0000FFFF);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    chk("pending_writes", 32'(expq.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
